// File: rtl/gf16_pkg.sv
// gf16_pkg: shared definitions for the GF(2^4) arithmetic blocks.
//   GF_POLY  - default low 4 bits of the reduction polynomial (x^4+x+1)
//   gf16_t   - 4-bit field element
//   state_t  - divider control states
//   gf16_sq  - field squaring, reduced by the given polynomial
package gf16_pkg;

    localparam logic [3:0] GF_POLY = 4'b0011;

    typedef logic [3:0] gf16_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Squaring is linear over GF(2): spread the bits to even powers, then
    // fold the x^6..x^4 terms back using x^4 = poly.
    function automatic gf16_t gf16_sq(input gf16_t x, input logic [3:0] poly);
        logic [6:0] v;
        v = {x[3], 1'b0, x[2], 1'b0, x[1], 1'b0, x[0]};
        for (int i = 6; i >= 4; i--) begin
            if (v[i]) begin
                v = v ^ (7'({1'b1, poly}) << (i - 4));
            end
        end
        return v[3:0];
    endfunction

endpackage

// File: rtl/gf16_mul.sv
// gf16_mul: combinational GF(2^4) multiplier.
//   POLY  - low 4 bits of the reduction polynomial (x^4 term implicit)
//   x, y  - operands
//   z     - x*y reduced modulo the polynomial
module gf16_mul
    import gf16_pkg::*;
#(
    parameter logic [3:0] POLY = GF_POLY
) (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [3:0] z
);

    logic [6:0] prod;

    always_comb begin
        prod = '0;
        // Carry-less product.
        for (int i = 0; i < 4; i++) begin
            if (y[i]) begin
                prod = prod ^ (7'(x) << i);
            end
        end
        // Reduce the high terms, highest first.
        for (int i = 6; i >= 4; i--) begin
            if (prod[i]) begin
                prod = prod ^ (7'({1'b1, POLY}) << (i - 4));
            end
        end
        z = prod[3:0];
    end

endmodule

// File: rtl/gf16_div.sv
// gf16_div: sequential GF(2^4) divider, z = a * b^-1.
// The inverse is formed as b^14 = b^2 * b^4 * b^8 over three CALC cycles using
// one shared multiplier, then FIN multiplies by the dividend.
//   clk, rst              - clock, asynchronous active-high reset
//   in_valid/in_ready     - operand handshake (a dividend, b divisor)
//   out_valid/out_ready   - result handshake
//   z                     - quotient
//   div_by_zero           - set alongside the result when b was zero
// Optional build macro GF16_DIV_FASTPATH_EN: b==1 or a==0 (with b!=0) bypass
// the iteration and present the result one cycle after acceptance.
module gf16_div
    import gf16_pkg::*;
#(
    parameter logic [3:0] POLY = GF_POLY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] z,
    output logic       div_by_zero
);

    state_t     state;
    gf16_t      p;
    gf16_t      acc;
    gf16_t      a_q;
    logic [1:0] cnt;

    gf16_t p_sq;
    gf16_t mul_y;
    gf16_t mul_z;

    assign in_ready = (state == IDLE);
    assign p_sq     = gf16_sq(p, POLY);
    // CALC accumulates powers of b; FIN applies the dividend.
    assign mul_y    = (state == CALC) ? p_sq : a_q;

    gf16_mul #(
        .POLY (POLY)
    ) u_mul (
        .x (acc),
        .y (mul_y),
        .z (mul_z)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            p           <= '0;
            acc         <= '0;
            a_q         <= '0;
            cnt         <= '0;
            z           <= '0;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q         <= a;
                        p           <= b;
                        acc         <= 4'h1;
                        cnt         <= '0;
                        div_by_zero <= (b == 4'h0);
`ifdef GF16_DIV_FASTPATH_EN
                        // a is already the answer for both b==1 and a==0.
                        if ((b != 4'h0) && ((b == 4'h1) || (a == 4'h0))) begin
                            z     <= a;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
`else
                        state       <= CALC;
`endif
                    end
                end
                CALC: begin
                    p   <= p_sq;
                    acc <= mul_z;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd2) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    z         <= mul_z;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
`ifdef GF16_DIV_FASTPATH_EN
                    // Fast path enters DONE with out_valid low; raise it here.
                    else if (!out_valid) begin
                        out_valid <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf16_div.sv
module tb_gf16_div;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] z;
    logic       div_by_zero;

    int total = 0;
    int bad   = 0;

    int exp_tab [0:14];
    int log_tab [0:15];

    gf16_div dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .z           (z),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Log/antilog model of GF(16) with x^4+x+1; alpha = 2 is primitive.
    function automatic void build_tables();
        int e;
        e = 1;
        for (int i = 0; i < 15; i++) begin
            exp_tab[i] = e;
            log_tab[e] = i;
            e = e * 2;
            if (e >= 16) e = e ^ 16 ^ 3;
        end
    endfunction

    function automatic int ref_mul(input int x, input int y);
        if (x == 0 || y == 0) return 0;
        return exp_tab[(log_tab[x] + log_tab[y]) % 15];
    endfunction

    function automatic int ref_div(input int x, input int y);
        if (x == 0 || y == 0) return 0;
        return exp_tab[(log_tab[x] - log_tab[y] + 15) % 15];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
        total++;
        assert (obs === want)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Full transaction: accept, measure latency, hold for `hold` cycles, drain.
    task automatic run_op(input int av, input int bv, input int hold);
        int n;
        int want_z;
        int want_lat;
        want_z   = ref_div(av, bv);
        want_lat = 4;
`ifdef GF16_DIV_FASTPATH_EN
        if (bv != 0 && (bv == 1 || av == 0)) want_lat = 1;
`endif
        @(negedge clk);
        check("in_ready_before", {7'd0, in_ready}, 8'd1);
        in_valid = 1'b1;
        a        = 4'(av);
        b        = 4'(bv);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 4'($urandom_range(0, 15));
        b        = 4'($urandom_range(0, 15));
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 8'(n), 8'(want_lat));
        check("z", {4'd0, z}, 8'(want_z));
        check("div_by_zero", {7'd0, div_by_zero}, (bv == 0) ? 8'd1 : 8'd0);
        if (bv != 0) check("z_times_b", 8'(ref_mul(int'(z), bv)), 8'(av));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {7'd0, out_valid}, 8'd1);
            check("hold_z", {4'd0, z}, 8'(want_z));
            check("hold_in_ready", {7'd0, in_ready}, 8'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_valid", {7'd0, out_valid}, 8'd0);
        check("drain_in_ready", {7'd0, in_ready}, 8'd1);
    endtask

    initial begin
        build_tables();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {7'd0, in_ready}, 8'd1);
        check("rst_out_valid", {7'd0, out_valid}, 8'd0);
        check("rst_z", {4'd0, z}, 8'd0);
        check("rst_dbz", {7'd0, div_by_zero}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // out_ready with nothing pending must not disturb IDLE.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_ready_noop", {7'd0, out_valid}, 8'd0);

        run_op(5, 2, 0);
        run_op(1, 3, 1);
        run_op(1, 2, 0);
        run_op(7, 7, 2);
        run_op(15, 0, 0);
        run_op(15, 1, 0);
        run_op(0, 9, 0);
        run_op(5, 2, 5);

        // Reset in the middle of CALC discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 4'd5;
        b        = 4'd2;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {7'd0, out_valid}, 8'd0);
        check("midrst_z", {4'd0, z}, 8'd0);
        check("midrst_in_ready", {7'd0, in_ready}, 8'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("midrst_quiet", {7'd0, out_valid}, 8'd0);
        end
        run_op(5, 2, 0);

        // Every operand pair with random backpressure.
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                run_op(av, bv, int'($urandom_range(0, 2)));
            end
        end

        // Random operands with longer stalls.
        repeat (20) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 6)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
